core_writeback: RTL and testbench

- Writer side of the core register file: collects completed results from the ALU and the load/store unit (LSU) and drives the file's single write port.
- Arbitrates between the two producers and buffers LSU results in a small FIFO.
- Maintains a per-register pending-write scoreboard, which the issue stage uses to detect read-after-write hazards.
- Sits between the execute/memory stages and core_regfile.

---
 rtl/core_writeback.sv | 152 +++++++++++++++
 tb/tb_core_writeback.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/core_writeback.sv
// Register-file writer: ALU/LSU arbitration, LSU result FIFO, pending-write scoreboard.
// Optional ALU starvation guard enabled by defining CORE_WB_STARVE_GUARD_EN.
module core_writeback #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int LSU_FIFO_DEPTH = 2,
  parameter int STARVE_LIMIT   = 3
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         alu_valid_i,
  output logic                         alu_ready_o,
  input  logic [ADDR_WIDTH-1:0]        alu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]        alu_rd_data_i,
  input  logic                         lsu_valid_i,
  output logic                         lsu_ready_o,
  input  logic [ADDR_WIDTH-1:0]        lsu_rd_addr_i,
  input  logic [DATA_WIDTH-1:0]        lsu_rd_data_i,
  input  logic                         issue_valid_i,
  input  logic [ADDR_WIDTH-1:0]        issue_rd_addr_i,
  output logic                         rd_we_o,
  output logic [ADDR_WIDTH-1:0]        rd_addr_o,
  output logic [DATA_WIDTH-1:0]        rd_data_o,
  output logic [(1<<ADDR_WIDTH)-1:0]   pending_o
);

  localparam int NREG = 1 << ADDR_WIDTH;
  localparam int PW   = $clog2(LSU_FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(LSU_FIFO_DEPTH);

  logic [ADDR_WIDTH-1:0] r_fifo_addr [LSU_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] r_fifo_data [LSU_FIFO_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;

  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [NREG-1:0]       r_pend;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_force;
  logic                  w_alu_go;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_win;
  logic [ADDR_WIDTH-1:0] w_win_addr;
  logic [DATA_WIDTH-1:0] w_win_data;
  logic [NREG-1:0]       w_pend_nxt;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == DEPTH_C);

  // FIFO head has priority unless the starvation guard forces the ALU in
  assign w_alu_go    = !rst_i && alu_valid_i && (w_empty || w_force);
  assign alu_ready_o = w_alu_go;
  assign lsu_ready_o = !rst_i && !w_full;

  assign w_push = lsu_valid_i && lsu_ready_o;
  assign w_pop  = !rst_i && !w_empty && !w_alu_go;
  assign w_win  = w_alu_go || w_pop;

  assign w_win_addr = w_alu_go ? alu_rd_addr_i : r_fifo_addr[r_rptr];
  assign w_win_data = w_alu_go ? alu_rd_data_i : r_fifo_data[r_rptr];

`ifdef CORE_WB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIMIT_C = SW'(STARVE_LIMIT);

  logic [SW-1:0] r_starve;

  assign w_force = alu_valid_i && (r_starve == LIMIT_C);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_starve <= '0;
    end else if (w_alu_go) begin
      r_starve <= '0;
    end else if (alu_valid_i && (r_starve != LIMIT_C)) begin
      r_starve <= r_starve + SW'(1);
    end
  end
`else
  logic w_unused_cfg;

  assign w_force      = 1'b0;
  assign w_unused_cfg = (STARVE_LIMIT > 0);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + PW'(1);
      if (w_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_addr[r_wptr] <= lsu_rd_addr_i;
      r_fifo_data[r_wptr] <= lsu_rd_data_i;
    end
  end

  // x0 winners still update addr/data but never raise the write enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_we   <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
    end else if (w_win) begin
      r_we   <= (w_win_addr != '0);
      r_addr <= w_win_addr;
      r_data <= w_win_data;
    end else begin
      r_we   <= 1'b0;
    end
  end

  // a same-cycle issue to the completing register keeps the bit set
  always_comb begin
    w_pend_nxt = r_pend;
    if (w_win)         w_pend_nxt[w_win_addr]      = 1'b0;
    if (issue_valid_i) w_pend_nxt[issue_rd_addr_i] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pend <= '0;
    end else begin
      r_pend <= w_pend_nxt;
    end
  end

  assign rd_we_o   = r_we;
  assign rd_addr_o = r_addr;
  assign rd_data_o = r_data;
  assign pending_o = r_pend;

endmodule

// File: tb/tb_core_writeback.sv
// Randomized + directed bench for core_writeback against a queue-based model.
// Model follows CORE_WB_STARVE_GUARD_EN the same way the DUT build does.
module tb_core_writeback;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;
  localparam int SLIM  = 3;
  localparam int NREG  = 1 << AW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic            av, ar, lv, lr, iv, we;
  logic [AW-1:0]   aa, la, ia, waddr;
  logic [DW-1:0]   ad, ld, wdata;
  logic [NREG-1:0] pend;

  core_writeback #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW),
    .LSU_FIFO_DEPTH(DEPTH), .STARVE_LIMIT(SLIM)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .alu_valid_i(av), .alu_ready_o(ar),
    .alu_rd_addr_i(aa), .alu_rd_data_i(ad),
    .lsu_valid_i(lv), .lsu_ready_o(lr),
    .lsu_rd_addr_i(la), .lsu_rd_data_i(ld),
    .issue_valid_i(iv), .issue_rd_addr_i(ia),
    .rd_we_o(we), .rd_addr_o(waddr), .rd_data_o(wdata),
    .pending_o(pend)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t            q[$];
  int              cnt;
  logic            e_we;
  logic [AW-1:0]   e_addr;
  logic [DW-1:0]   e_data;
  logic [NREG-1:0] e_pend;
  int              checks = 0;
  int              fails  = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic r,
                      input logic v_a, input logic [AW-1:0] a_a,
                      input logic [DW-1:0] d_a,
                      input logic v_l, input logic [AW-1:0] a_l,
                      input logic [DW-1:0] d_l,
                      input logic v_i, input logic [AW-1:0] a_i);
    bit            m_ar, m_lr, frc, win;
    ent_t          e;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    rst = r; av = v_a; aa = a_a; ad = d_a;
    lv = v_l; la = a_l; ld = d_l; iv = v_i; ia = a_i;
    #1;
    m_ar = 1'b0;
    m_lr = 1'b0;
    frc  = 1'b0;
    if (!r) begin
`ifdef CORE_WB_STARVE_GUARD_EN
      frc = v_a && (cnt == SLIM);
`endif
      m_ar = v_a && (q.size() == 0 || frc);
      m_lr = q.size() < DEPTH;
    end
    chk("alu_ready", {63'd0, ar}, {63'd0, m_ar});
    chk("lsu_ready", {63'd0, lr}, {63'd0, m_lr});
    if (r) begin
      q.delete();
      cnt    = 0;
      e_we   = 1'b0;
      e_addr = '0;
      e_data = '0;
      e_pend = '0;
    end else begin
      win = 1'b0;
      wa  = '0;
      wd  = '0;
      if (m_ar) begin
        win = 1'b1; wa = a_a; wd = d_a;
      end else if (q.size() != 0) begin
        e = q.pop_front();
        win = 1'b1; wa = e.a; wd = e.d;
      end
      if (v_l && m_lr) q.push_back('{a: a_l, d: d_l});
      if (win) begin
        e_we = (wa != 0);
        e_addr = wa;
        e_data = wd;
        e_pend[wa] = 1'b0;
      end else begin
        e_we = 1'b0;
      end
      if (v_i && a_i != 0) e_pend[a_i] = 1'b1;
      if (m_ar) cnt = 0;
      else if (v_a && cnt < SLIM) cnt++;
    end
    @(posedge clk);
    #1;
    chk("rd_we",   {63'd0, we},    {63'd0, e_we});
    chk("rd_addr", {59'd0, waddr}, {59'd0, e_addr});
    chk("rd_data", {32'd0, wdata}, {32'd0, e_data});
    chk("pending", {32'd0, pend},  {32'd0, e_pend});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    cnt = 0; e_we = 0; e_addr = '0; e_data = '0; e_pend = '0;
    step(1, 1, 5, 32'h1, 1, 6, 32'h2, 1, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 5);
    step(0, 1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("alu_wr_pend5", {63'd0, pend[5]}, 64'd0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 1, 3);
    step(0, 0, 0, 0, 0, 0, 0, 1, 4);
    step(0, 1, 3, 32'h11, 1, 4, 32'h22, 0, 0);
    idle(3);
    step(0, 0, 0, 0, 1, 8, 32'h80, 0, 0);
    step(0, 0, 0, 0, 1, 9, 32'h90, 0, 0);
    step(0, 0, 0, 0, 1, 10, 32'hA0, 0, 0);
    idle(3);
    step(0, 1, 12, 32'hC0, 1, 13, 32'hD0, 0, 0);
    step(0, 1, 12, 32'hC0, 1, 14, 32'hE0, 0, 0);
    step(0, 1, 12, 32'hC0, 1, 15, 32'hF0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 12, 32'hC0, 0, 0, 0, 0, 0);
    idle(2);
    step(0, 1, 0, 32'hFFFFFFFF, 0, 0, 0, 0, 0);
    chk("x0_we", {63'd0, we}, 64'd0);
    chk("x0_pend0", {63'd0, pend[0]}, 64'd0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7);
    step(0, 1, 7, 32'h77, 0, 0, 0, 1, 7);
    chk("collide_pend7", {63'd0, pend[7]}, 64'd1);
    idle(1);
    for (int i = 0; i < 6; i++)
      step(0, 1, 20, 32'h200 + i, 1, AW'(21 + i), 32'h300 + i, 1, 22);
    step(1, 1, 20, 32'h1, 1, 21, 32'h2, 1, 22);
    chk("rst_pend", {32'd0, pend}, 64'd0);
    idle(4);
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 50) == 0,
           ($urandom % 2) == 0, AW'($urandom), $urandom,
           ($urandom % 2) == 0, AW'($urandom), $urandom,
           ($urandom % 10) < 3, AW'($urandom));
    end
    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
